// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared constants, types and helpers for the iterative AES-128 datapath.
//   AES_BLOCK_W : width of a state word / round key
//   NUM_ROUNDS  : rounds after the initial whitening (AES-128)
//   ark_state_e : AddRoundKey stage control states
//   rcon()      : round-constant byte for rounds 1..10
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned NUM_ROUNDS  = 10;

    // ST_IDLE: no key held; ST_RUN: key held, rounds being processed.
    typedef enum logic [0:0] {
        ST_IDLE,
        ST_RUN
    } ark_state_e;

    // Round constant for the key-schedule step producing round key r.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aes_add_round_key_stage_if.sv
// ----------------------------------------------------------------------------
// aes_add_round_key_stage_if
// Handshake bundle for the AddRoundKey stage.
//   key_valid/key_ready/key_in      : cipher key load channel
//   in_valid/in_ready/in_state      : incoming state word channel
//   out_valid/out_ready/out_state,
//   out_round/out_last              : registered result channel
// Modports: slave (the stage), master (the driver / environment).
// ----------------------------------------------------------------------------
interface aes_add_round_key_stage_if;
    import aes_pkg::*;

    logic                   key_valid;
    logic                   key_ready;
    logic [AES_BLOCK_W-1:0] key_in;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_BLOCK_W-1:0] in_state;

    logic                   out_valid;
    logic                   out_ready;
    logic [AES_BLOCK_W-1:0] out_state;
    logic [3:0]             out_round;
    logic                   out_last;

    modport slave (
        input  key_valid, key_in, in_valid, in_state, out_ready,
        output key_ready, in_ready, out_valid, out_state, out_round, out_last
    );

    modport master (
        output key_valid, key_in, in_valid, in_state, out_ready,
        input  key_ready, in_ready, out_valid, out_state, out_round, out_last
    );

endinterface

// File: rtl/aes_sbox.sv
// ----------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// (modulus x^8+x^4+x^3+x+1, with 0 mapping to 0) followed by the affine map.
//   in_byte  : input byte
//   out_byte : substituted byte
// ----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Inverse as x^254 via an addition chain; x^254 of 0 is 0 as required.
    always_comb begin
        x2   = gf_mul(in_byte, in_byte);
        x3   = gf_mul(x2, in_byte);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/aes_add_round_key_stage.sv
// ----------------------------------------------------------------------------
// aes_add_round_key_stage
// AddRoundKey stage of the iterative AES-128 encryptor. Holds the cipher key,
// expands one round key per accepted state word and XORs it into the state.
// Wraps to round 0 after round NUM_ROUNDS so successive blocks share the key.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : key / in / out handshake channels (slave side)
// ----------------------------------------------------------------------------
module aes_add_round_key_stage #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    aes_add_round_key_stage_if.slave   bus
);
    import aes_pkg::*;

    ark_state_e             state_q, state_d;
    logic [3:0]             rnd_q, rnd_d;
    logic [AES_BLOCK_W-1:0] rk_q, rk_d;
    logic [AES_BLOCK_W-1:0] key_reg_q, key_reg_d;
    logic                   out_valid_q, out_valid_d;
    logic [AES_BLOCK_W-1:0] out_state_q, out_state_d;
    logic [3:0]             out_round_q, out_round_d;
    logic                   out_last_q, out_last_d;

    logic                   key_ready, key_take;
    logic                   in_ready, in_take;
    logic                   last_rnd;

    logic [31:0]            w0, w1, w2, w3;
    logic [31:0]            rot_word, sub_word, t_word;
    logic [31:0]            n0, n1, n2, n3;
    logic [AES_BLOCK_W-1:0] rk_next;

    // Round-key schedule step: w0 is the leftmost column.
    assign w0       = rk_q[127:96];
    assign w1       = rk_q[95:64];
    assign w2       = rk_q[63:32];
    assign w3       = rk_q[31:0];
    assign rot_word = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*g +: 8]),
            .out_byte (sub_word[8*g +: 8])
        );
    end

    assign t_word  = sub_word ^ {rcon(rnd_q + 4'd1), 24'h0};
    assign n0      = w0 ^ t_word;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    always_comb begin
        last_rnd  = (rnd_q == 4'(NUM_ROUNDS));
        // Key loads are only allowed between blocks so a block never mixes keys.
        key_ready = (state_q == ST_IDLE) || (rnd_q == 4'd0);
        key_take  = bus.key_valid && key_ready;
        in_ready  = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready) && !key_take;
        in_take   = bus.in_valid && in_ready;
    end

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        rk_d        = rk_q;
        key_reg_d   = key_reg_q;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;

        // Output register is independent of a key load: a pending result
        // computed under the old key stays until it is consumed.
        if (in_take) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (key_take) begin
            state_d   = ST_RUN;
            key_reg_d = bus.key_in;
            rk_d      = bus.key_in;
            rnd_d     = '0;
        end else if (in_take) begin
            out_state_d = bus.in_state ^ rk_q;
            out_round_d = rnd_q;
            out_last_d  = last_rnd;
            if (last_rnd) begin
                rk_d  = key_reg_q;
                rnd_d = '0;
            end else begin
                rk_d  = rk_next;
                rnd_d = rnd_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rnd_q       <= '0;
            rk_q        <= '0;
            key_reg_q   <= '0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            rk_q        <= rk_d;
            key_reg_q   <= key_reg_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.key_ready = key_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;
    assign bus.out_round = out_round_q;
    assign bus.out_last  = out_last_q;

endmodule
